bus_ram_responder: RTL

// - Memory-side responder for the CPU data bus: accepts sized load/store requests (STUR/STURW/STURH/STURB,

---
 rtl/bus_ram_responder_pkg.sv | 45 ++++
 rtl/bus_ram_responder_if.sv | 26 ++
 rtl/bus_ram_responder_lane_merge.sv | 36 +++
 rtl/bus_ram_responder.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/bus_ram_responder_pkg.sv
// Shared types for the bus RAM responder: access size encodings, FSM states
// and size helpers used by both the top level and the lane merge logic.
package bus_ram_responder_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE   = 2'b00,
        SZ_HALF   = 2'b01,
        SZ_WORD   = 2'b10,
        SZ_DOUBLE = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_WAIT   = 2'b01,
        ST_ACCESS = 2'b10,
        ST_DONE   = 2'b11
    } state_e;

    function automatic logic [3:0] size_bytes(input size_e sz);
        logic [3:0] n;
        n = 4'd8;
        case (sz)
            SZ_BYTE:   n = 4'd1;
            SZ_HALF:   n = 4'd2;
            SZ_WORD:   n = 4'd4;
            SZ_DOUBLE: n = 4'd8;
            default:   n = 4'd8;
        endcase
        return n;
    endfunction

    function automatic logic [7:0] size_byte_mask(input size_e sz);
        logic [7:0] m;
        m = '1;
        case (sz)
            SZ_BYTE:   m = 8'h01;
            SZ_HALF:   m = 8'h03;
            SZ_WORD:   m = 8'h0F;
            SZ_DOUBLE: m = 8'hFF;
            default:   m = '1;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/bus_ram_responder_if.sv
// CPU data bus as seen by the RAM responder; the master issues requests,
// the slave (RAM) returns data, output enable and completion pulses.
interface bus_ram_responder_if;

    logic        sel;
    logic        rd_en;
    logic        wr_en;
    logic [1:0]  size;
    logic [31:0] address;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic        data_oe;
    logic        ready;
    logic        error;

    modport master (
        output sel, rd_en, wr_en, size, address, wdata,
        input  rdata, data_oe, ready, error
    );

    modport slave (
        input  sel, rd_en, wr_en, size, address, wdata,
        output rdata, data_oe, ready, error
    );

endinterface

// File: rtl/bus_ram_responder_lane_merge.sv
// Byte-lane logic for one 64-bit entry: merges sized store data into the old
// entry (little-endian) and extracts right-justified, zero-extended load data.
module ram_lane_merge
    import bus_ram_responder_pkg::*;
(
    input  logic [63:0] old_entry,
    input  logic [63:0] wdata,
    input  logic [2:0]  lane,
    input  size_e       size,
    output logic [63:0] merged,
    output logic [7:0]  byte_en,
    output logic [63:0] load_data
);

    logic [7:0]  mask;
    logic [63:0] wdata_shifted;
    logic [63:0] bit_mask;
    logic [5:0]  shamt;

    always_comb begin
        mask          = size_byte_mask(size);
        shamt         = {lane, 3'b000};
        byte_en       = mask << lane;
        wdata_shifted = wdata << shamt;
        bit_mask      = '0;
        merged        = old_entry;
        for (int unsigned i = 0; i < 8; i++) begin
            bit_mask[i*8 +: 8] = {8{mask[i]}};
            if (byte_en[i]) begin
                merged[i*8 +: 8] = wdata_shifted[i*8 +: 8];
            end
        end
        load_data = (old_entry >> shamt) & bit_mask;
    end

endmodule

// File: rtl/bus_ram_responder.sv
// RAM-side responder for the CPU data bus: captures a sized load/store,
// waits a fixed number of cycles, then completes with a ready or error pulse.
module bus_ram_responder
    import bus_ram_responder_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2  = 8,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 1
)(
    input  logic                clock,
    input  logic                reset,
    bus_ram_responder_if.slave  bus
);

    localparam int unsigned ENTRIES   = 1 << DEPTH_LOG2;
    localparam logic [3:0]  WAIT_LAST = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    logic [63:0] mem [ENTRIES];

    state_e      state_q, state_d;
    logic [3:0]  wait_q, wait_d;

    logic [31:0] addr_q;
    size_e       size_q;
    logic [63:0] wdata_q;
    logic        write_q;

    logic [63:0] rdata_q;
    logic        data_oe_q;
    logic        ready_q;
    logic        error_q;

    logic        req_valid;
    logic        req_conflict;
    logic        enter_access;
    logic        reject;

    logic [31:0] acc_addr;
    size_e       acc_size;
    logic [63:0] acc_wdata;
    logic        acc_write;
    logic [31:0] offset;
    logic [3:0]  nbytes;
    logic [2:0]  align_mask;
    logic        acc_ok;
    logic [DEPTH_LOG2-1:0] index;

    logic [63:0] old_entry;
    logic [63:0] merged;
    logic [7:0]  byte_en;
    logic [63:0] load_data;

    assign req_valid    = bus.sel & (bus.rd_en ^ bus.wr_en);
    assign req_conflict = bus.sel & bus.rd_en & bus.wr_en;

    // With zero wait states the access happens straight out of IDLE, so the
    // operands come from the live bus rather than the capture registers.
    always_comb begin
        acc_addr   = addr_q;
        acc_size   = size_q;
        acc_wdata  = wdata_q;
        acc_write  = write_q;
        if (state_q == ST_IDLE) begin
            acc_addr  = bus.address;
            acc_size  = size_e'(bus.size);
            acc_wdata = bus.wdata;
            acc_write = bus.wr_en;
        end
        offset     = acc_addr - BASE_ADDR;
        nbytes     = size_bytes(acc_size);
        align_mask = 3'(nbytes - 4'd1);
        acc_ok     = (acc_addr >= BASE_ADDR)
                   && ((offset >> (DEPTH_LOG2 + 3)) == 32'd0)
                   && ((acc_addr[2:0] & align_mask) == 3'd0);
        index      = offset[DEPTH_LOG2+2:3];
        old_entry  = mem[index];
    end

    ram_lane_merge u_lane_merge (
        .old_entry (old_entry),
        .wdata     (acc_wdata),
        .lane      (acc_addr[2:0]),
        .size      (acc_size),
        .merged    (merged),
        .byte_en   (byte_en),
        .load_data (load_data)
    );

    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        enter_access = 1'b0;
        reject       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_conflict) begin
                    reject  = 1'b1;
                    state_d = ST_ACCESS;
                end else if (req_valid) begin
                    if (WAIT_STATES == 0) begin
                        enter_access = 1'b1;
                        state_d      = ST_ACCESS;
                    end else begin
                        wait_d  = '0;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!bus.sel) begin
                    state_d = ST_IDLE;
                end else if (wait_q == WAIT_LAST) begin
                    enter_access = 1'b1;
                    state_d      = ST_ACCESS;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            ST_ACCESS: state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Completion outputs are registered on the edge into ACCESS so that
    // ready/error, rdata and data_oe are all valid during the ACCESS cycle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            wait_q    <= '0;
            rdata_q   <= '0;
            data_oe_q <= 1'b0;
            ready_q   <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            ready_q <= 1'b0;
            error_q <= 1'b0;
            if (reject) begin
                error_q <= 1'b1;
            end else if (enter_access) begin
                if (!acc_ok) begin
                    error_q <= 1'b1;
                    rdata_q <= '0;
                end else begin
                    ready_q <= 1'b1;
                    if (!acc_write) begin
                        rdata_q   <= load_data;
                        data_oe_q <= 1'b1;
                    end
                end
            end
            if (state_q == ST_DONE) begin
                data_oe_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (state_q == ST_IDLE && req_valid) begin
            addr_q  <= bus.address;
            size_q  <= size_e'(bus.size);
            wdata_q <= bus.wdata;
            write_q <= bus.wr_en;
        end
    end

    always_ff @(posedge clock) begin
        if (reset && enter_access && acc_ok && acc_write) begin
            mem[index] <= merged;
        end
    end

    assign bus.rdata   = rdata_q;
    assign bus.data_oe = data_oe_q;
    assign bus.ready   = ready_q;
    assign bus.error   = error_q;

endmodule
